// File: rtl/nic8_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nic8_pkg: shared state encoding and bus widths for the nic8 run controller
// Rev 1.0
// ----------------------------------------------------------------------------
package nic8_pkg;
    localparam int c_STATE_W = 3;
    localparam int c_ADDR_W  = 8;
    localparam int c_DATA_W  = 8;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        STEP = 3'd3,
        HALT = 3'd4
    } state_t;
endpackage
`default_nettype wire

// File: rtl/run_control_loadport.sv
`default_nettype none
// ----------------------------------------------------------------------------
// run_control_loadport: loader handshake and registered RAM write stage
// Rev 1.0
// ----------------------------------------------------------------------------
module run_control_loadport
    import nic8_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_load,
    input  logic                load_valid,
    input  logic [c_ADDR_W-1:0] load_addr,
    input  logic [c_DATA_W-1:0] load_data,
    output logic                load_ready,
    output logic                ld_we,
    output logic [c_ADDR_W-1:0] ld_addr,
    output logic [c_DATA_W-1:0] ld_data
);
    logic                w_accept;
    logic                r_we;
    logic [c_ADDR_W-1:0] r_addr;
    logic [c_DATA_W-1:0] r_data;

    assign w_accept   = in_load & load_valid;
    assign load_ready = w_accept;

    // Address/data hold their last captured value between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_addr <= load_addr;
                r_data <= load_data;
            end
        end
    end

    assign ld_we   = r_we;
    assign ld_addr = r_addr;
    assign ld_data = r_data;
endmodule
`default_nettype wire

// File: rtl/run_control.sv
`default_nettype none
// ----------------------------------------------------------------------------
// run_control: run/halt/step sequencer, PC breakpoint, step budget, RAM arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module run_control
    import nic8_pkg::*;
#(
    parameter int unsigned STEP_LIMIT = 0,
    parameter int          CW         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_req,
    input  logic                 halt_req,
    input  logic                 step_req,
    input  logic                 bp_enable,
    input  logic [c_ADDR_W-1:0]  bp_addr,
    input  logic [c_ADDR_W-1:0]  pc,
    input  logic                 load_valid,
    input  logic                 load_last,
    input  logic [c_ADDR_W-1:0]  load_addr,
    input  logic [c_DATA_W-1:0]  load_data,
    output logic                 load_ready,
    output logic                 cpu_en,
    output logic                 mem_sel,
    output logic                 ld_we,
    output logic [c_ADDR_W-1:0]  ld_addr,
    output logic [c_DATA_W-1:0]  ld_data,
    output logic [c_STATE_W-1:0] state,
    output logic [CW-1:0]        step_count,
    output logic                 halted_at_bp
);
    state_t        r_state;
    logic          r_first;
    logic          r_hbp;
    logic [CW-1:0] r_count;
    logic          w_bp_hit;
    logic          w_limit_hit;
    logic          w_cpu_en;
    logic          w_ld_we;

    // r_first masks the breakpoint for the first RUN cycle so a resume from bp_addr proceeds.
    assign w_bp_hit    = (r_state == RUN) && bp_enable && (pc == bp_addr) && !r_first;
    assign w_limit_hit = (STEP_LIMIT != 0) && (r_count == CW'(STEP_LIMIT));

    always_comb begin
        w_cpu_en = 1'b0;
        case (r_state)
            RUN:     w_cpu_en = !w_bp_hit && !w_limit_hit;
            STEP:    w_cpu_en = !w_limit_hit;
            default: w_cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_first <= 1'b0;
            r_hbp   <= 1'b0;
            r_count <= '0;
        end else begin
            r_first <= 1'b0;
            if (w_cpu_en && (r_count != {CW{1'b1}}))
                r_count <= r_count + CW'(1);
            case (r_state)
                IDLE, HALT: begin
                    if (halt_req) begin
                        r_state <= r_state;
                    end else if (step_req) begin
                        r_state <= STEP;
                        r_hbp   <= 1'b0;
                    end else if (run_req) begin
                        r_state <= RUN;
                        r_first <= 1'b1;
                        r_hbp   <= 1'b0;
                    end else if (load_valid) begin
                        r_state <= LOAD;
                        r_hbp   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_valid && load_last)
                        r_state <= IDLE;
                end
                RUN: begin
                    if (w_bp_hit) begin
                        r_state <= HALT;
                        r_hbp   <= 1'b1;
                    end else if (halt_req || w_limit_hit) begin
                        r_state <= HALT;
                    end
                end
                STEP:    r_state <= HALT;
                default: r_state <= IDLE;
            endcase
        end
    end

    run_control_loadport u_loadport (
        .clk        (clk),
        .reset      (reset),
        .in_load    (r_state == LOAD),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ld_we      (w_ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    // The loader keeps the RAM through the cycle that carries its final write.
    assign mem_sel      = (r_state == LOAD) || w_ld_we;
    assign ld_we        = w_ld_we;
    assign cpu_en       = w_cpu_en;
    assign state        = r_state;
    assign step_count   = r_count;
    assign halted_at_bp = r_hbp;
endmodule
`default_nettype wire

// File: tb/tb_run_control.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_run_control: vector table plus load scoreboard for run_control
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_run_control;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
    logic       bp_enable = 1'b1;
    logic [7:0] bp_addr = 8'h05;
    logic [7:0] pc = 8'h00;
    logic       load_valid = 1'b0, load_last = 1'b0;
    logic [7:0] load_addr = 8'h00, load_data = 8'h00;

    logic        load_ready, cpu_en, mem_sel, ld_we, halted_at_bp;
    logic [7:0]  ld_addr, ld_data;
    logic [2:0]  state;
    logic [15:0] step_count;

    logic        l_load_ready, l_cpu_en, l_mem_sel, l_ld_we, l_halted_at_bp;
    logic [7:0]  l_ld_addr, l_ld_data;
    logic [2:0]  l_state;
    logic [15:0] l_step_count;

    logic        s_load_ready, s_cpu_en, s_mem_sel, s_ld_we, s_halted_at_bp;
    logic [7:0]  s_ld_addr, s_ld_data;
    logic [2:0]  s_state;
    logic [1:0]  s_step_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] sb[$];

    typedef struct {
        logic [2:0]  rhs;
        logic        lv, ll;
        logic [7:0]  la, ldat, pcv;
        logic [2:0]  st;
        logic        cen, rdy, ms, we;
        logic [15:0] cnt;
        logic        hbp;
    } vec_t;
    vec_t vq[$];

    always #5 clk = ~clk;

    run_control u_dut (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc), .load_valid(load_valid),
        .load_last(load_last), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .cpu_en(cpu_en), .mem_sel(mem_sel), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_data(ld_data), .state(state), .step_count(step_count),
        .halted_at_bp(halted_at_bp)
    );

    run_control #(.STEP_LIMIT(4), .CW(16)) u_lim (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc), .load_valid(load_valid),
        .load_last(load_last), .load_addr(load_addr), .load_data(load_data),
        .load_ready(l_load_ready), .cpu_en(l_cpu_en), .mem_sel(l_mem_sel), .ld_we(l_ld_we),
        .ld_addr(l_ld_addr), .ld_data(l_ld_data), .state(l_state), .step_count(l_step_count),
        .halted_at_bp(l_halted_at_bp)
    );

    run_control #(.STEP_LIMIT(0), .CW(2)) u_sat (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc), .load_valid(load_valid),
        .load_last(load_last), .load_addr(load_addr), .load_data(load_data),
        .load_ready(s_load_ready), .cpu_en(s_cpu_en), .mem_sel(s_mem_sel), .ld_we(s_ld_we),
        .ld_addr(s_ld_addr), .ld_data(s_ld_data), .state(s_state), .step_count(s_step_count),
        .halted_at_bp(s_halted_at_bp)
    );

    function automatic vec_t mk(input logic [2:0] rhs, input logic lv, input logic ll,
                                input logic [7:0] la, input logic [7:0] ldat, input logic [7:0] pcv,
                                input logic [2:0] st, input logic cen, input logic rdy,
                                input logic ms, input logic we, input logic [15:0] cnt,
                                input logic hbp);
        vec_t v;
        v.rhs = rhs; v.lv = lv; v.ll = ll; v.la = la; v.ldat = ldat; v.pcv = pcv;
        v.st = st; v.cen = cen; v.rdy = rdy; v.ms = ms; v.we = we; v.cnt = cnt; v.hbp = hbp;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [15:0] e;
        @(negedge clk);
        {run_req, halt_req, step_req} = v.rhs;
        load_valid = v.lv; load_last = v.ll; load_addr = v.la; load_data = v.ldat; pc = v.pcv;
        #2;
        chk("state", idx, 16'(state), 16'(v.st));
        chk("cpu_en", idx, 16'(cpu_en), 16'(v.cen));
        chk("load_ready", idx, 16'(load_ready), 16'(v.rdy));
        chk("mem_sel", idx, 16'(mem_sel), 16'(v.ms));
        chk("ld_we", idx, 16'(ld_we), 16'(v.we));
        chk("step_count", idx, step_count, v.cnt);
        chk("halted_at_bp", idx, 16'(halted_at_bp), 16'(v.hbp));
        if (ld_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("ld_sb_unexpected", idx, 16'(ld_we), 16'd0);
            end else begin
                e = sb.pop_front();
                chk("ld_addr", idx, 16'(ld_addr), 16'(e[15:8]));
                chk("ld_data", idx, 16'(ld_data), 16'(e[7:0]));
            end
        end
        if (v.rdy && v.lv) sb.push_back({v.la, v.ldat});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Load burst; run_req in LOAD is ignored; halt_req in IDLE stays IDLE.
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 16'd0, 0));
        vq.push_back(mk(3'b000, 1, 0, 8'h00, 8'hA5, 8'h00, 3'd0, 0, 0, 0, 0, 16'd0, 0));
        vq.push_back(mk(3'b000, 1, 0, 8'h00, 8'hA5, 8'h00, 3'd1, 0, 1, 1, 0, 16'd0, 0));
        vq.push_back(mk(3'b100, 1, 0, 8'h01, 8'h3C, 8'h00, 3'd1, 0, 1, 1, 1, 16'd0, 0));
        vq.push_back(mk(3'b000, 1, 1, 8'h02, 8'hFF, 8'h00, 3'd1, 0, 1, 1, 1, 16'd0, 0));
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 1, 1, 16'd0, 0));
        vq.push_back(mk(3'b010, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 16'd0, 0));
        // Run to breakpoint at 05.
        vq.push_back(mk(3'b100, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 16'd0, 0));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'(i), 3'd2, 1, 0, 0, 0, 16'(i), 0));
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h05, 3'd2, 0, 0, 0, 0, 16'd5, 0));
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h05, 3'd4, 0, 0, 0, 0, 16'd5, 1));
        // Resume from the breakpoint, load_valid ignored in RUN, then halt_req.
        vq.push_back(mk(3'b100, 0, 0, 8'h00, 8'h00, 8'h05, 3'd4, 0, 0, 0, 0, 16'd5, 1));
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h05, 3'd2, 1, 0, 0, 0, 16'd5, 0));
        vq.push_back(mk(3'b000, 1, 0, 8'h33, 8'h44, 8'h06, 3'd2, 1, 0, 0, 0, 16'd6, 0));
        vq.push_back(mk(3'b010, 0, 0, 8'h00, 8'h00, 8'h07, 3'd2, 1, 0, 0, 0, 16'd7, 0));
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h08, 3'd4, 0, 0, 0, 0, 16'd8, 0));
        // Single step (step beats load_valid), then all requests together in HALT.
        vq.push_back(mk(3'b001, 1, 0, 8'h00, 8'h00, 8'h08, 3'd4, 0, 0, 0, 0, 16'd8, 0));
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h08, 3'd3, 1, 0, 0, 0, 16'd8, 0));
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h09, 3'd4, 0, 0, 0, 0, 16'd9, 0));
        vq.push_back(mk(3'b111, 0, 0, 8'h00, 8'h00, 8'h09, 3'd4, 0, 0, 0, 0, 16'd9, 0));
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h09, 3'd4, 0, 0, 0, 0, 16'd9, 0));
        // halt_req together with a breakpoint hit, then a step over the breakpoint.
        vq.push_back(mk(3'b100, 0, 0, 8'h00, 8'h00, 8'h05, 3'd4, 0, 0, 0, 0, 16'd9, 0));
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h05, 3'd2, 1, 0, 0, 0, 16'd9, 0));
        vq.push_back(mk(3'b010, 0, 0, 8'h00, 8'h00, 8'h05, 3'd2, 0, 0, 0, 0, 16'd10, 0));
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h05, 3'd4, 0, 0, 0, 0, 16'd10, 1));
        vq.push_back(mk(3'b001, 0, 0, 8'h00, 8'h00, 8'h05, 3'd4, 0, 0, 0, 0, 16'd10, 1));
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h05, 3'd3, 1, 0, 0, 0, 16'd10, 0));
        vq.push_back(mk(3'b000, 0, 0, 8'h00, 8'h00, 8'h05, 3'd4, 0, 0, 0, 0, 16'd11, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vq.size(); i++)
            apply(vq[i], i);

        // Reset asserted mid-LOAD drops the pending write.
        @(negedge clk);
        {run_req, halt_req, step_req} = 3'b000;
        load_valid = 1'b1; load_last = 1'b0; load_addr = 8'h10; load_data = 8'h55;
        @(negedge clk);
        #2;
        chk("rst_pre_state", 0, 16'(state), 16'd1);
        chk("rst_pre_ready", 0, 16'(load_ready), 16'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; load_valid = 1'b0;
        #2;
        chk("rst_ld_we", 0, 16'(ld_we), 16'd0);
        chk("rst_state", 0, 16'(state), 16'd0);
        chk("rst_count", 0, step_count, 16'd0);
        chk("rst_mem_sel", 0, 16'(mem_sel), 16'd0);
        chk("rst_hbp", 0, 16'(halted_at_bp), 16'd0);

        // Step budget of 4, then a step that the exhausted budget suppresses.
        @(negedge clk);
        bp_enable = 1'b0; pc = 8'h00; run_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            run_req = 1'b0;
            #2;
            chk("lim_cpu_en", i, 16'(l_cpu_en), 16'(i < 4));
            chk("lim_count", i, l_step_count, 16'(i));
            chk("lim_state", i, 16'(l_state), 16'd2);
        end
        @(negedge clk);
        #2;
        chk("lim_halt_state", 0, 16'(l_state), 16'd4);
        chk("lim_halt_count", 0, l_step_count, 16'd4);
        chk("lim_halt_cpu_en", 0, 16'(l_cpu_en), 16'd0);
        chk("lim_halt_hbp", 0, 16'(l_halted_at_bp), 16'd0);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        #2;
        chk("lim_step_state", 0, 16'(l_state), 16'd3);
        chk("lim_step_cpu_en", 0, 16'(l_cpu_en), 16'd0);
        @(negedge clk);
        #2;
        chk("lim_after_state", 0, 16'(l_state), 16'd4);
        chk("lim_after_count", 0, l_step_count, 16'd4);
        chk("sat_count", 0, 16'(s_step_count), 16'd3);
        chk("sat_cpu_en", 0, 16'(s_cpu_en), 16'd1);
        chk("sb_empty", 0, 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/run_control.md
Name: run_control

Overview:
- Run/halt/step sequencer for the nic8 CPU core, which executes one instruction per enabled clock.
- Drives the core's clock-enable and enforces a breakpoint on PC and an optional step budget.
- Arbitrates the shared program memory between the core and an external byte loader, so RAM can be filled while the core is stopped.
- Sits between the top level (host/bench stimulus) and the core/RAM. The monitor observes the core independently.

Parameters:
- STEP_LIMIT, 0, halt after this many enabled cycles; 0 = unlimited.
- CW, 16, width of step_count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run_req  in  1  pulse: start/resume free running
- halt_req  in  1  pulse: stop at next cycle boundary
- step_req  in  1  pulse: execute exactly one instruction
- bp_enable  in  1  breakpoint armed
- bp_addr  in  8  breakpoint PC value
- pc  in  8  current core PC
- load_valid  in  1  loader has a byte
- load_last  in  1  qualifies final byte of a load burst
- load_addr  in  8  loader target address
- load_data  in  8  loader byte
- load_ready  out  1  loader byte accepted this cycle
- cpu_en  out  1  core register-load enable (instruction executes when 1)
- mem_sel  out  1  0 = core owns RAM, 1 = loader owns RAM
- ld_we  out  1  registered RAM write strobe, loader side
- ld_addr  out  8  registered RAM address, loader side
- ld_data  out  8  registered RAM data, loader side
- state  out  3  current state encoding
- step_count  out  CW  enabled cycles since reset; saturates at all-ones
- halted_at_bp  out  1  last halt was caused by the breakpoint

Behaviour:
- Reset, synchronous, active-high, dominates everything:
  - state=IDLE.
  - All outputs 0.
  - Internal first-cycle flag cleared.
  - A reset mid-load drops any pending write: ld_we=0 next cycle.
- States: IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4. Codes 5–7 are illegal and go to IDLE.
- Request priority when simultaneous: halt_req > step_req > run_req > load_valid.
- IDLE / HALT:
  - cpu_en=0, mem_sel=0.
  - halt_req: stay.
  - step_req → STEP.
  - run_req → RUN.
  - else load_valid → LOAD.
  - Entering HALT from IDLE is not possible.
- LOAD:
  - mem_sel=1, cpu_en=0.
  - load_ready = load_valid (combinational).
  - On each accepted byte, the next cycle has ld_we=1 and ld_addr/ld_data = captured values (1-cycle latency); otherwise ld_we=0.
  - Accepted byte with load_last=1 → IDLE. mem_sel stays 1 through the cycle carrying that final ld_we, then returns to 0.
  - run_req/step_req/halt_req are ignored in LOAD.
- RUN:
  - first flag is set on entry and cleared after one cycle.
  - bp_hit = bp_enable & (pc==bp_addr) & !first.
  - cpu_en = !bp_hit & !limit_hit (combinational from state, pc, flags).
  - bp_hit → HALT with halted_at_bp=1; the instruction at bp_addr is not executed.
  - halt_req → HALT with halted_at_bp=0; the cycle carrying halt_req still executes.
  - If halt_req and bp_hit occur together: go to HALT, halted_at_bp=1, cpu_en=0.
  - limit_hit = (STEP_LIMIT!=0) & (step_count==STEP_LIMIT) → HALT, cpu_en=0.
  - load_valid is ignored (load_ready=0).
- STEP:
  - cpu_en=1 for exactly one cycle; the breakpoint is ignored.
  - The limit is still honoured: if limit_hit, cpu_en=0.
  - Always → HALT; halted_at_bp=0.
- step_count increments on every cycle with cpu_en=1 and saturates at 2^CW−1.
- halted_at_bp clears on the next entry to RUN, STEP or LOAD.

Decomposition:
- Shared package (nic8_pkg): state encoding localparams (IDLE..HALT) and width 3; address/data width 8.
- Sub-module run_control_loadport: load handshake plus the registered ld_we/ld_addr/ld_data stage. Inputs: accept and load bits. Output: write path.
- The FSM, breakpoint compare and counter stay in run_control.

Test Plan:
- Load: reset, then 3 bytes (00:A5, 01:3C, 02:FF, last on 3rd) → load_ready high 3 cycles; ld_we on the following 3 cycles with matching addr/data; mem_sel back to 0 after; state=IDLE.
- Breakpoint: bp_enable=1, bp_addr=05, run_req, pc counts 00..05 → cpu_en=1 for pc 00–04, 0 at 05; state=HALT; halted_at_bp=1; step_count=5.
- Resume from breakpoint: then run_req with pc=05 → cpu_en=1 in first RUN cycle (breakpoint skipped); halted_at_bp=0.
- Single step: from HALT, step_req pulse → exactly one cycle cpu_en=1; step_count+1; state HALT.
- Priority: step_req+run_req+halt_req together in HALT → stay HALT, cpu_en=0. In RUN, halt_req with pc==bp_addr → HALT, halted_at_bp=1, no execution.
- Limit and reset: STEP_LIMIT=4, run_req → cpu_en high 4 cycles, then HALT with step_count=4. Reset asserted mid-LOAD with load_valid=1 → next cycle ld_we=0, state=IDLE, step_count=0.
